// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready, flush and lock-bus stall.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int                DATA_W    = 128,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                LOCK_W    = 5,
  parameter int                STALL_BIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [LOCK_W-1:0] lock_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  generate
    if (STALL_BIT < 0 || STALL_BIT >= LOCK_W) begin : g_bad_stall_bit
      $error("pipe_stage_skid: STALL_BIT must index lock_i");
    end
    if (DATA_W < 1) begin : g_bad_data_w
      $error("pipe_stage_skid: DATA_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                main_v;
  logic                skid_v;
  logic [DATA_W-1:0]   main_d;
  logic [DATA_W-1:0]   skid_d;
  logic                locked;
  logic                in_fire;
  logic                out_fire;
  logic                in_ready_nxt;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid;
  logic                unused_lock;

  // Only one bit of the shared lock bus belongs to this stage.
  assign unused_lock = ^lock_i;
  assign locked      = lock_i[STALL_BIT];

  assign main_v   = (state != EMPTY);
  assign skid_v   = (state == FULL);
  assign in_fire  = in_valid & in_ready & ~locked;
  assign out_fire = out_valid & out_ready;

  // State register: control only; payload registers below need no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= in_ready_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else if (!locked) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b11: load_main_in = 1'b1;
            2'b10: begin
              state_nxt = FULL;
              load_skid = 1'b1;
            end
            2'b01: state_nxt = EMPTY;
            default: state_nxt = ONE;
          endcase
        end
        FULL: begin
          // in_ready is low while FULL, so only a drain can happen here.
          if (out_fire) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready depends only on registered state and the lock, never on out_ready.
  assign in_ready_nxt = (state_nxt != FULL) & ~locked;

  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_d <= in_data;
    end else if (load_main_skid) begin
      main_d <= skid_d;
    end
    if (load_skid) begin
      skid_d <= in_data;
    end
  end

  always_comb begin
    out_valid = main_v & ~locked;
    out_data  = main_v ? main_d : NOP_VALUE;
    occupancy = state;
  end

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters ignore flush so a cleaned pipeline still reports its history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= 16'h0000;
      bubble_cnt <= 16'h0000;
    end else begin
      if (locked) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (!out_valid && !locked) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end
`else
  assign stall_cnt  = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid (DATA_W=8): directed vectors feed an expected queue,
// a negedge monitor pops and compares on every output transfer.
module tb_pipe_stage_skid;

  logic       clk;
  logic       rst;
  logic       flush_i;
  logic [4:0] lock_i;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  pipe_stage_skid #(
    .DATA_W(8),
    .NOP_VALUE(8'h00),
    .LOCK_W(5),
    .STALL_BIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush_i),
    .lock_i(lock_i),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a payload, wait (bounded) for an accepting cycle, record it as expected.
  task automatic send(input logic [7:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !lock_i[2] && !flush_i) begin
        exp_q.push_back(d);
        done = 1;
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got no accept, required accept of %0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_out: got %0h, required no transfer", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          mismatched++;
          $display("FAIL out_data_order: got %0h, required %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush_i   = 1'b0;
    lock_i    = 5'b00000;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;

    // Reset release
    repeat (3) tick();
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    check("rst_bubble_cnt", bubble_cnt, 16'h0);
    rst = 1'b0;
    send(8'hA5);
    check("first_out_valid", out_valid, 1'b1);
    check("first_out_data", out_data, 8'hA5);
    tick();
    check("first_drained", occupancy, 2'd0);

    // Skid fill
    out_ready = 1'b0;
    send(8'h11);
    check("one_in_ready", in_ready, 1'b1);
    send(8'h22);
    check("full_occupancy", occupancy, 2'd2);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_data", out_data, 8'h11);
    out_ready = 1'b1;
    tick();
    check("skid_second_out", out_data, 8'h22);
    check("skid_after_one", occupancy, 2'd1);
    tick();
    check("skid_empty", occupancy, 2'd0);

    // Streaming
    for (int i = 1; i <= 10; i++) begin
      send(i[7:0]);
      check("stream_occupancy", occupancy, 2'd1);
    end
    repeat (2) tick();
    check("stream_drained", occupancy, 2'd0);
    check("stream_queue_empty", exp_q.size(), 0);

    // Lock at occupancy 1
    out_ready = 1'b0;
    send(8'h33);
    lock_i    = 5'b00100;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    #1;
    check("lock_out_valid_now", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lock_out_valid", out_valid, 1'b0);
      check("lock_in_ready", in_ready, 1'b0);
      check("lock_occupancy", occupancy, 2'd1);
    end
    in_valid = 1'b0;
    lock_i   = 5'b00000;
    #1;
    check("unlock_out_valid", out_valid, 1'b1);
    check("unlock_out_data", out_data, 8'h33);
    tick();
    check("unlock_drained", occupancy, 2'd0);

    // Other lock bits are ignored
    lock_i = 5'b11011;
    tick();
    send(8'h55);
    check("otherbits_in_ready", in_ready, 1'b1);
    check("otherbits_out_valid", out_valid, 1'b1);
    tick();
    lock_i = 5'b00000;
    check("otherbits_drained", occupancy, 2'd0);

    // Flush collision with lock and incoming payload
    out_ready = 1'b0;
    send(8'hA1);
    send(8'hA2);
    check("preflush_occupancy", occupancy, 2'd2);
    flush_i  = 1'b1;
    lock_i   = 5'b00100;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    flush_i  = 1'b0;
    lock_i   = 5'b00000;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("flush_occupancy", occupancy, 2'd0);
    check("flush_out_data", out_data, 8'h00);
    check("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_still_empty", occupancy, 2'd0);

    // Perf counters
    rst    = 1'b1;
    lock_i = 5'b00100;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    lock_i = 5'b00000;
    repeat (5) tick();
`ifdef PIPE_STAGE_PERF_EN
    check("perf_stall_cnt", stall_cnt, 16'd3);
    check("perf_bubble_cnt", bubble_cnt, 16'd5);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("perf_flush_keeps", stall_cnt, 16'd3);
    lock_i = 5'b00100;
    repeat (65540) tick();
    check("perf_stall_sat", stall_cnt, 16'hFFFF);
    tick();
    check("perf_stall_hold", stall_cnt, 16'hFFFF);
    lock_i = 5'b00000;
`else
    check("perf_stall_tied", stall_cnt, 16'h0);
    check("perf_bubble_tied", bubble_cnt, 16'h0);
`endif

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register that succeeds the fixed-field ID/EX latch. It carries one opaque DATA_W-bit payload, such as a packed aluop/alusel/operands/wd/wreg/link_pc/offset bundle, using a valid/ready handshake. A 2-entry skid buffer makes in_ready registered, so there is no combinational path from out_ready to in_ready. The legacy lock bus and clean (flush) input are kept, so the block drops in between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 128, payload width in bits (min 1).
NOP_VALUE, {DATA_W{1'b0}}, value driven on out_data while the stage is empty; an all-zero bundle decodes as NOP, wreg=WriteDisable.
LOCK_W, 5, width of the shared pipeline lock bus.
STALL_BIT, 2, index of lock_i that freezes this stage (0..LOCK_W-1).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
flush_i  in  1  clean request; empties the stage on next edge
lock_i  in  LOCK_W  pipeline lock bus; bit STALL_BIT freezes this stage
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept (registered)
in_data  in  DATA_W  upstream payload
out_valid  out  1  payload valid toward downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload toward downstream
occupancy  out  2  number of held entries, 0..2
stall_cnt  out  16  perf: locked cycles (see Optional Feature)
bubble_cnt  out  16  perf: empty-output cycles (see Optional Feature)

Behaviour:
- Storage: main entry (main_v, main_d) and skid entry (skid_v, skid_d). The skid is only ever valid while main is valid.
- State is implied by occupancy: EMPTY(0), ONE(1), FULL(2).
- Reset (async, rst=1): main_v=0, skid_v=0, out_valid=0, out_data=NOP_VALUE, in_ready=0 while rst is held, occupancy=0, counters=0.
- in_ready is registered: 1 iff skid_v=0 after the edge and the stage is not locked. It goes to 1 on the first edge after rst falls.
- out_valid = main_v & ~lock_i[STALL_BIT].
- out_data = main_d when main_v, else NOP_VALUE.
- Handshake definitions:
  - in_fire = in_valid & in_ready & ~lock_i[STALL_BIT].
  - out_fire = out_valid & out_ready.
- Latency: a payload accepted at edge N is on out_data with out_valid=1 after edge N (1 cycle). Ordering is strict FIFO.
- Transitions with no flush and no lock:
  - EMPTY + in_fire -> ONE (main<=in).
  - ONE + in_fire & out_fire -> ONE (main<=in).
  - ONE + in_fire & ~out_fire -> FULL (skid<=in).
  - ONE + ~in_fire & out_fire -> EMPTY.
  - FULL + out_fire -> ONE (main<=skid, skid_v<=0). in_ready is 0 in FULL, so there is no in_fire.
- Lock (lock_i[STALL_BIT]=1): contents frozen, out_valid=0, no in_fire, in_ready=0 on the next edge. Releasing the lock resumes with the same contents. Other lock bits are ignored.
- Flush (flush_i=1): at the next edge main_v=0 and skid_v=0, and out_data returns to NOP_VALUE. A simultaneous in_fire payload is discarded.
- Priority: rst > flush_i > lock > normal operation.
- in_valid may drop without a transfer; no X propagates from in_data when in_valid=0.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments every cycle lock_i[STALL_BIT]=1.
  - bubble_cnt increments every cycle out_valid=0 while not locked and not in reset.
  - Both counters saturate at 16'hFFFF, clear on rst, and are unaffected by flush_i.
- Undefined: no counter logic is generated; stall_cnt and bubble_cnt are tied to 16'h0000.

Test Plan:
- Reset release, DATA_W=8, NOP_VALUE=8'h00: rst held 3 cycles, then in_valid=1, in_data=8'hA5 -> out_data=8'h00 and in_ready=0 during reset; out_valid=1, out_data=8'hA5 one cycle after the first accept edge.
- Skid fill, out_ready=0: push 8'h11 then 8'h22 -> occupancy=2, in_ready=0, out_data=8'h11. Raise out_ready -> 8'h11 then 8'h22 come out on consecutive cycles, then occupancy=0.
- Streaming: in_valid=out_ready=1 with payloads 1..10 -> out_data is 1..10 on consecutive cycles, occupancy stays 1, no loss or duplication.
- Lock with lock_i=5'b00100 for 4 cycles at occupancy=1 holding 8'h33 -> out_valid=0 and in_ready=0 during the lock. After release, out_data=8'h33 with out_valid=1. lock_i=5'b11011 has no effect.
- Flush collision: occupancy=2, flush_i=1 with in_valid=1, in_data=8'h77, and lock asserted -> next cycle occupancy=0, out_data=8'h00, out_valid=0, and 8'h77 never appears.
- PIPE_STAGE_PERF_EN defined: lock for 3 cycles, then 5 idle cycles -> stall_cnt=3, bubble_cnt=5. Preload a counter to 16'hFFFF and keep the condition active -> value holds at 16'hFFFF.
